// File: rtl/synth_reset_pkg.sv
// Shared definitions for the reset request generator: FSM states, cause
// bit positions and counter width helper.
package synth_reset_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int CAUSE_KEY = 0;
  localparam int CAUSE_PLL = 1;
  localparam int CAUSE_SW  = 2;
  localparam int CAUSE_W   = 3;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a stable-count filter. With SYMMETRIC=0
// only the rising direction is filtered; a low input clears the output at once.
module sync_debounce
  import synth_reset_pkg::*;
#(
  parameter int   COUNT       = 4,
  parameter logic RESET_LEVEL = 1'b0,
  parameter bit   SYMMETRIC   = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level
);

  localparam int            CW   = cnt_width(COUNT);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RESET_LEVEL;
      r_sync <= RESET_LEVEL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  // The counter only runs while the synchronized input disagrees with the output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_level <= RESET_LEVEL;
      r_cnt   <= '0;
    end else if (r_sync == r_level) begin
      r_cnt <= '0;
    end else if (!SYMMETRIC && !r_sync) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_cnt == LAST) begin
      r_level <= r_sync;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/reset_request_gen.sv
// Merges global reset, debounced push-button, qualified PLL lock and a software
// pulse into one registered active-low reset request with a minimum width.
module reset_request_gen
  import synth_reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LOCK_CYCLES     = 1024,
  parameter int MIN_ASSERT      = 256
) (
  input  logic               iCLK,
  input  logic               reset_reg,
  input  logic               iKEY_N,
  input  logic               iPLL_LOCKED,
  input  logic               iSW_RST,
  output logic               oRESET_N,
  output logic [CAUSE_W-1:0] oCAUSE,
  output logic [1:0]         oSTATE
);

  localparam int            HW        = cnt_width(MIN_ASSERT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_ASSERT - 1);

  logic               w_key_level;
  logic               w_key_db;
  logic               w_lock_ok;
  logic [CAUSE_W-1:0] w_trig;
  state_e             w_next;

  state_e             r_state;
  logic [HW-1:0]      r_hold_cnt;
  logic [CAUSE_W-1:0] r_cause;

  sync_debounce #(
    .COUNT       (DEBOUNCE_CYCLES),
    .RESET_LEVEL (1'b1),
    .SYMMETRIC   (1'b1)
  ) u_key (
    .i_clk   (iCLK),
    .i_rst   (reset_reg),
    .i_async (iKEY_N),
    .o_level (w_key_level)
  );

  sync_debounce #(
    .COUNT       (LOCK_CYCLES),
    .RESET_LEVEL (1'b0),
    .SYMMETRIC   (1'b0)
  ) u_lock (
    .i_clk   (iCLK),
    .i_rst   (reset_reg),
    .i_async (iPLL_LOCKED),
    .o_level (w_lock_ok)
  );

  assign w_key_db          = ~w_key_level;
  assign w_trig[CAUSE_KEY] = w_key_db;
  assign w_trig[CAUSE_PLL] = ~w_lock_ok;
  assign w_trig[CAUSE_SW]  = iSW_RST;

  // A software pulse always restarts the hold window; key and lock only gate release.
  always_comb begin
    w_next = r_state;
    case (r_state)
      HOLD: begin
        if (iSW_RST) begin
          w_next = HOLD;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (iSW_RST) begin
          w_next = HOLD;
        end else if (!w_key_db && w_lock_ok) begin
          w_next = RUN;
        end
      end
      RUN: begin
        if (|w_trig) begin
          w_next = HOLD;
        end
      end
      default: w_next = HOLD;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (reset_reg) begin
      r_state    <= HOLD;
      r_hold_cnt <= '0;
      r_cause    <= '0;
      oRESET_N   <= 1'b0;
    end else begin
      r_state  <= w_next;
      oRESET_N <= (w_next == RUN);

      if (w_next == HOLD && (r_state != HOLD || iSW_RST)) begin
        r_hold_cnt <= '0;
      end else if (r_state == HOLD) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end

      if (r_state == RUN && w_next == HOLD) begin
        r_cause <= w_trig;
      end else if (r_state != RUN && iSW_RST) begin
        r_cause[CAUSE_SW] <= 1'b1;
      end
    end
  end

  assign oCAUSE = r_cause;
  assign oSTATE = r_state;

endmodule

// File: doc/reset_request_gen.md
# reset_request_gen

Front-end reset conditioner for the synthesizer. It merges four reset sources into one clean, qualified, active-low reset request, `oRESET_N`, which drives the `reset_reg_N` input of the staggered reset-delay stage:
- the global synchronous reset;
- a bouncing push-button;
- PLL lock status;
- a one-cycle software reset pulse.

It synchronizes and filters the asynchronous inputs, enforces a minimum assertion width, and records which source caused the last reset.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before the debounced key changes (1 ms at 50 MHz).
- `LOCK_CYCLES`, default 1024: consecutive synchronized-locked cycles required before PLL lock is qualified.
- `MIN_ASSERT`, default 256: minimum number of cycles `oRESET_N` stays low per assertion. Must be ≥1.

Ports:
- `iCLK` — in, 1: the single clock.
- `reset_reg` — in, 1: synchronous, active-high reset.
- `iKEY_N` — in, 1: asynchronous push-button; 0 = pressed.
- `iPLL_LOCKED` — in, 1: asynchronous PLL lock; 1 = locked.
- `iSW_RST` — in, 1: synchronous one-cycle software reset request.
- `oRESET_N` — out, 1: registered reset request; 0 = reset. Feeds the downstream `reset_reg_N`.
- `oCAUSE` — out, 3: `{sw, pll, key}` cause of the current or last assertion. 000 = power-on / `reset_reg`.
- `oSTATE` — out, 2: FSM state (HOLD=0, WAIT=1, RUN=2).

## Operation
- **Synchronizers:** two-flop synchronizers on `iKEY_N` and `iPLL_LOCKED`.
  - Reset values: key stage = 1 (released), lock stage = 0.
- **Key debounce:**
  - `key_db` (1 = pressed) resets to 0.
  - The counter clears whenever the synchronized (inverted) key equals `key_db`.
  - `key_db` takes the new value on the edge where the counter reaches `DEBOUNCE_CYCLES-1` with the input still differing.
- **Lock qualification:**
  - `lock_ok` resets to 0.
  - `lock_ok` sets after `LOCK_CYCLES` consecutive cycles of synchronized lock = 1.
  - `lock_ok` clears on the first edge where synchronized lock = 0. There is no filtering on loss of lock.
- **FSM:**
  - HOLD: `oRESET_N`=0. `hold_cnt` increments each cycle. On the edge where `hold_cnt` reaches `MIN_ASSERT`, go to WAIT.
  - WAIT: `oRESET_N`=0. Go to RUN when `key_db`=0, `lock_ok`=1 and `iSW_RST`=0.
  - RUN: `oRESET_N`=1. If `key_db`=1, `lock_ok`=0 or `iSW_RST`=1, go to HOLD with `hold_cnt`=0.
- **Software pulse while already in reset:** `iSW_RST`=1 in HOLD or WAIT re-enters HOLD with `hold_cnt`=0 (retrigger). Key and lock conditions only gate WAIT→RUN.
- **Cause recording:**
  - `oCAUSE` is overwritten on the RUN→HOLD edge with the OR of all simultaneously active triggers.
  - In HOLD/WAIT, `iSW_RST` ORs in bit 2.
- **Output register:** `oRESET_N` is a register loaded with (next_state == RUN). It must be glitch-free.
- **Reset values (`reset_reg`=1):** state HOLD, `hold_cnt`=0, `oRESET_N`=0, `oCAUSE`=000, `oSTATE`=0, `key_db`=0, `lock_ok`=0, all counters 0.

## Timing
Edges are numbered from the first edge after `reset_reg` falls.
- **Lock path:** with `iPLL_LOCKED` high throughout, synchronized lock = 1 from edge 2 and `lock_ok` = 1 at edge `2+LOCK_CYCLES`.
- **Power-up release:** HOLD→WAIT at edge `MIN_ASSERT`. `oRESET_N` rises at edge `max(MIN_ASSERT, 2+LOCK_CYCLES)+1`.
- **`iSW_RST` in RUN:** `oRESET_N`=0 at the next edge (latency 1).
- **Key press:** `iKEY_N` low and stable from edge e gives `key_db`=1 at `e+1+DEBOUNCE_CYCLES` and `oRESET_N`=0 one edge later. Bounces shorter than `DEBOUNCE_CYCLES` produce no change.
- **Lock loss at edge e:** `lock_ok`=0 at e+2, `oRESET_N`=0 at e+3.
- **Held key:** `oRESET_N` stays low indefinitely, then rises no earlier than `DEBOUNCE_CYCLES` after release and no earlier than `MIN_ASSERT` after HOLD entry.
- **`reset_reg` mid-operation:** forces the reset values on the next edge and overrides all other inputs.

## Structure
- **Shared package `synth_reset_pkg`:**
  - state enum (HOLD/WAIT/RUN);
  - cause bit indices (`CAUSE_KEY`=0, `CAUSE_PLL`=1, `CAUSE_SW`=2);
  - counter widths derived with `$clog2` of the parameters.
- **One sub-module `sync_debounce`:** 2FF synchronizer plus stable-count filter, parameterized by count and reset level.
  - Instantiated for the key with symmetric filtering.
  - The lock path uses the same synchronizer, but qualification applies on rising lock only.

## Test plan
Parameters `MIN_ASSERT`=16, `LOCK_CYCLES`=8, `DEBOUNCE_CYCLES`=20 unless stated.
1. `reset_reg` for 3 cycles, lock high, key released → `oRESET_N` rises exactly at edge 17; `oCAUSE`=000; `oSTATE` goes 0 → 1 → 2.
2. In RUN, `iSW_RST` pulse at edge e → `oRESET_N`=0 at e+1 and rises at e+18; `oCAUSE`=100.
3. In RUN, `iKEY_N` bounces with low runs of 5 cycles, then is held low 30 cycles → a single assertion starting 22 cycles after the stable low begins; `oCAUSE`=001; release only after the key has been stable high 20 cycles.
4. In RUN, `iPLL_LOCKED` drops for 1 cycle at edge e → `oRESET_N`=0 at e+3; `oCAUSE`=010; release no earlier than 8 qualified lock cycles later and no earlier than 16 cycles in HOLD.
5. `iSW_RST` pulses every 10 cycles while in HOLD → `oRESET_N` stays low; it rises 17 cycles after the last pulse; `oCAUSE` bit 2 is set.
6. `reset_reg` asserted mid-WAIT → next edge shows `oRESET_N`=0, `oSTATE`=0, `oCAUSE`=000; the scenario 1 timing then repeats.
